// File: rtl/spi_master_arbiter.sv
// Round-robin SPI master: shares one bus among NUM_REQ requesters, one slave select each,
// shifts a DATA_WIDTH word MSB-first and captures the MISO word in the same transfer.
module spi_master_arbiter #(
    parameter int   DATA_WIDTH = 8,
    parameter int   NUM_REQ    = 4,
    parameter int   CLK_DIV    = 4,
    parameter logic CPOL       = 1'b0,
    parameter logic CPHA       = 1'b0,
    parameter int   SS_SETUP   = 2,
    parameter int   SS_HOLD    = 2
) (
    input  logic                          clk_m,
    input  logic                          rst,
    input  logic [NUM_REQ-1:0]            req,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
    output logic [NUM_REQ-1:0]            grant,
    output logic                          done,
    output logic [DATA_WIDTH-1:0]         rx_data,
    output logic                          sclk,
    output logic [NUM_REQ-1:0]            ss,
    output logic                          mosi,
    input  logic                          miso
);
    localparam int PTR_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int EDGE_W  = $clog2(2*DATA_WIDTH) + 1;
    localparam int CNT_MAX = (SS_SETUP > SS_HOLD) ? SS_SETUP : SS_HOLD;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam logic [EDGE_W-1:0] LAST_EDGE = EDGE_W'(2*DATA_WIDTH);

    typedef enum logic [2:0] {IDLE, SETUP, XFER, HOLD, GAP} state_t;

    state_t                             state;
    logic [PTR_W-1:0]                   ptr;
    logic [CNT_W-1:0]                   cnt;
    logic [DIV_W-1:0]                   div_cnt;
    logic [EDGE_W-1:0]                  edge_cnt;
    logic [DATA_WIDTH-1:0]              tx_sr;
    logic [DATA_WIDTH-1:0]              rx_sr;
    logic [NUM_REQ-1:0][DATA_WIDTH-1:0] req_words;

    logic                               sel_found;
    logic [PTR_W-1:0]                   sel_idx;
    logic [NUM_REQ-1:0]                 sel_oh;
    logic [EDGE_W-1:0]                  e_next;
    logic                               do_sample;
    logic                               do_shift;

    assign req_words = req_data;

    function automatic logic [PTR_W-1:0] wrap_idx(input int v);
        return PTR_W'((v >= NUM_REQ) ? v - NUM_REQ : v);
    endfunction

    // First set request at or after the pointer, wrapping around.
    always_comb begin
        sel_found = 1'b0;
        sel_idx   = ptr;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (!sel_found && req[wrap_idx(int'(ptr) + k)]) begin
                sel_found = 1'b1;
                sel_idx   = wrap_idx(int'(ptr) + k);
            end
        end
    end

    assign sel_oh = NUM_REQ'(1) << sel_idx;

    // e_next is the number of the sclk edge produced at this divider wrap.
    assign e_next    = edge_cnt + 1'b1;
    assign do_sample = CPHA ? ~e_next[0] : e_next[0];
    assign do_shift  = CPHA ? (e_next[0] && e_next != EDGE_W'(1))
                            : (~e_next[0] && e_next != LAST_EDGE);

    always_ff @(posedge clk_m or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            ptr      <= '0;
            cnt      <= '0;
            div_cnt  <= '0;
            edge_cnt <= '0;
            tx_sr    <= '0;
            rx_sr    <= '0;
            grant    <= '0;
            done     <= 1'b0;
            rx_data  <= '0;
            sclk     <= CPOL;
            ss       <= '1;
            mosi     <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (sel_found) begin
                        tx_sr <= req_words[sel_idx];
                        mosi  <= req_words[sel_idx][DATA_WIDTH-1];
                        grant <= sel_oh;
                        ss    <= ~sel_oh;
                        ptr   <= (sel_idx == PTR_W'(NUM_REQ-1)) ? '0 : sel_idx + PTR_W'(1);
                        cnt   <= '0;
                        state <= SETUP;
                    end
                end
                SETUP: begin
                    if (cnt == CNT_W'(SS_SETUP-1)) begin
                        cnt      <= '0;
                        div_cnt  <= '0;
                        edge_cnt <= '0;
                        rx_sr    <= '0;
                        state    <= XFER;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                XFER: begin
                    if (div_cnt == DIV_W'(CLK_DIV-1)) begin
                        div_cnt  <= '0;
                        edge_cnt <= e_next;
                        if (e_next == LAST_EDGE) begin
                            sclk  <= CPOL;
                            cnt   <= '0;
                            state <= HOLD;
                        end else begin
                            sclk <= ~sclk;
                        end
                        if (do_sample)
                            rx_sr <= {rx_sr[DATA_WIDTH-2:0], miso};
                        if (do_shift) begin
                            tx_sr <= {tx_sr[DATA_WIDTH-2:0], 1'b0};
                            mosi  <= tx_sr[DATA_WIDTH-2];
                        end
                    end else begin
                        div_cnt <= div_cnt + 1'b1;
                    end
                end
                HOLD: begin
                    if (cnt == CNT_W'(SS_HOLD-1)) begin
                        ss      <= '1;
                        grant   <= '0;
                        rx_data <= rx_sr;
                        done    <= 1'b1;
                        mosi    <= 1'b0;
                        state   <= GAP;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                // One guaranteed deselect cycle before the next arbitration.
                GAP:     state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_spi_master_arbiter.sv
// Scoreboard bench: four CPOL/CPHA instances share one stimulus stream, plus a
// DATA_WIDTH=16 / CLK_DIV=2 instance for the end-to-end latency case.
module tb_spi_master_arbiter;
    localparam int NI = 4;

    logic        clk_m = 1'b0;
    logic        rst;
    logic [3:0]  req;
    logic [31:0] req_data;
    logic        loop;
    logic [7:0]  slave_word;

    logic [3:0]  grant_a [NI];
    logic [3:0]  ss_a    [NI];
    logic [7:0]  rx_a    [NI];
    logic        sclk_a  [NI];
    logic        mosi_a  [NI];
    logic        done_a  [NI];
    logic        miso_a  [NI];

    logic [3:0]  req5;
    logic [63:0] data5;
    logic [3:0]  grant5, ss5;
    logic [15:0] rx5;
    logic        done5, sclk5, mosi5;

    typedef struct packed {
        logic [3:0] g;
        logic [7:0] tx;
        logic [7:0] rx;
    } exp_t;

    exp_t exp_q[$];
    int   lat_q[$];
    int   rd       [NI];
    int   ecnt     [NI];
    int   done_cnt [NI];
    logic [7:0] sreg [NI];
    logic [7:0] cap  [NI];
    logic       sclk_p [NI];
    logic [3:0] prev_g [NI];
    logic [3:0] last_g [NI];
    int   checks = 0;
    int   failures = 0;
    int   viol = 0;
    int   cyc = 0;

    always #5 clk_m = ~clk_m;
    always @(posedge clk_m) cyc <= cyc + 1;

    for (genvar g = 0; g < NI; g++) begin : g_mode
        assign miso_a[g] = loop ? mosi_a[g] : sreg[g][7];
        spi_master_arbiter #(.CPOL(1'(g/2)), .CPHA(1'(g%2))) u_dut (
            .clk_m(clk_m), .rst(rst), .req(req), .req_data(req_data),
            .grant(grant_a[g]), .done(done_a[g]), .rx_data(rx_a[g]),
            .sclk(sclk_a[g]), .ss(ss_a[g]), .mosi(mosi_a[g]), .miso(miso_a[g]));
    end

    spi_master_arbiter #(.DATA_WIDTH(16), .CLK_DIV(2)) u_dut16 (
        .clk_m(clk_m), .rst(rst), .req(req5), .req_data(data5),
        .grant(grant5), .done(done5), .rx_data(rx5),
        .sclk(sclk5), .ss(ss5), .mosi(mosi5), .miso(mosi5));

    function automatic logic cpol_of(input int m);
        return (m / 2) != 0;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req_v);
        checks++;
        if (act !== req_v) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, req_v);
        end
    endtask

    // Monitor + per-instance slave model.
    always @(negedge clk_m) begin : mon
        exp_t x;
        for (int m = 0; m < NI; m++) begin
            if (!rst && done_a[m]) begin
                done_cnt[m]++;
                if (rd[m] >= exp_q.size()) begin
                    chk($sformatf("unexpected_done m%0d", m), 1, 0);
                end else begin
                    x = exp_q[rd[m]];
                    chk($sformatf("rx_data m%0d t%0d", m, rd[m]), rx_a[m], x.rx);
                    chk($sformatf("grant m%0d t%0d", m, rd[m]), last_g[m], x.g);
                    chk($sformatf("mosi_word m%0d t%0d", m, rd[m]), cap[m], x.tx);
                    chk($sformatf("edges m%0d t%0d", m, rd[m]), ecnt[m], 16);
                    rd[m]++;
                end
            end
            if (!rst) begin
                if ($countones(~ss_a[m]) > 1) viol++;
                if (ss_a[m] !== ~grant_a[m]) viol++;
                if (ss_a[m] == 4'hF && sclk_a[m] !== cpol_of(m)) viol++;
                if (prev_g[m] != 0 && grant_a[m] != 0 && grant_a[m] != prev_g[m]) viol++;
            end
            if (ss_a[m] == 4'hF) begin
                ecnt[m] = 0;
                sreg[m] = slave_word;
                cap[m]  = 8'h00;
            end else if (sclk_a[m] !== sclk_p[m]) begin
                ecnt[m]++;
                if ((m % 2 == 0) ? (ecnt[m] % 2 == 1) : (ecnt[m] % 2 == 0))
                    cap[m] = {cap[m][6:0], mosi_a[m]};
                if ((m % 2 == 0) ? (ecnt[m] % 2 == 0 && ecnt[m] < 16)
                                 : (ecnt[m] % 2 == 1 && ecnt[m] > 1))
                    sreg[m] = {sreg[m][6:0], 1'b0};
            end
            sclk_p[m] = sclk_a[m];
            prev_g[m] = grant_a[m];
            if (grant_a[m] != 0) last_g[m] = grant_a[m];
        end
        if (!rst && done5) begin
            if (lat_q.size() == 0) begin
                chk("unexpected_done16", 1, 0);
            end else begin
                chk("done16_cycle", cyc, lat_q.pop_front());
                chk("rx16_loopback", {16'h0, rx5}, 32'h0000BEEF);
            end
        end
    end

    task automatic wait_done(input string name);
        int n = 0;
        do begin
            @(negedge clk_m);
            n++;
        end while (!done_a[0] && n < 300);
        if (!done_a[0]) chk({"timeout ", name}, 0, 1);
    endtask

    task automatic push(input logic [3:0] g, input logic [7:0] tx, input logic [7:0] rx);
        exp_t x;
        x.g = g; x.tx = tx; x.rx = rx;
        exp_q.push_back(x);
    endtask

    initial begin
        int n, d0, flag;
        for (int m = 0; m < NI; m++) begin
            rd[m] = 0; ecnt[m] = 0; done_cnt[m] = 0; sreg[m] = 0; cap[m] = 0;
            sclk_p[m] = 0; prev_g[m] = 0; last_g[m] = 0;
        end
        rst = 1'b1; req = 4'h0; req_data = 32'h0; loop = 1'b0; slave_word = 8'h3C;
        req5 = 4'h0; data5 = 64'h0;
        repeat (3) @(negedge clk_m);
        for (int m = 0; m < NI; m++) begin
            chk($sformatf("rst_grant m%0d", m), grant_a[m], 4'h0);
            chk($sformatf("rst_ss m%0d", m), ss_a[m], 4'hF);
            chk($sformatf("rst_sclk m%0d", m), sclk_a[m], cpol_of(m));
            chk($sformatf("rst_mosi m%0d", m), mosi_a[m], 1'b0);
            chk($sformatf("rst_done m%0d", m), done_a[m], 1'b0);
            chk($sformatf("rst_rx m%0d", m), rx_a[m], 8'h00);
        end
        rst = 1'b0;
        @(negedge clk_m);

        // All four requesting: round-robin 0,1,2,3,0
        req_data = {8'h44, 8'h33, 8'h22, 8'h11};
        push(4'b0001, 8'h11, 8'h3C); push(4'b0010, 8'h22, 8'h3C);
        push(4'b0100, 8'h33, 8'h3C); push(4'b1000, 8'h44, 8'h3C);
        push(4'b0001, 8'h11, 8'h3C);
        req = 4'hF;
        repeat (5) wait_done("rr");
        req = 4'h0;

        // Single transfer A5 out, slave returns 3C
        repeat (3) @(negedge clk_m);
        req_data[7:0] = 8'hA5;
        push(4'b0001, 8'hA5, 8'h3C);
        req = 4'b0001;
        wait_done("a5");
        req = 4'h0;

        // Loopback 81 on requester 1
        repeat (3) @(negedge clk_m);
        loop = 1'b1;
        req_data[15:8] = 8'h81;
        push(4'b0010, 8'h81, 8'h81);
        req = 4'b0010;
        wait_done("loop81");
        req = 4'h0;
        loop = 1'b0;

        // Reset at edge 7 of a transfer
        repeat (3) @(negedge clk_m);
        req = 4'b0001;
        n = 0;
        do begin
            @(negedge clk_m); #1;
            n++;
        end while (ecnt[0] != 7 && n < 300);
        if (ecnt[0] != 7) chk("timeout edge7", ecnt[0], 7);
        rst = 1'b1;
        req = 4'h0;
        @(negedge clk_m);
        for (int m = 0; m < NI; m++) begin
            chk($sformatf("midrst_ss m%0d", m), ss_a[m], 4'hF);
            chk($sformatf("midrst_sclk m%0d", m), sclk_a[m], cpol_of(m));
            chk($sformatf("midrst_grant m%0d", m), grant_a[m], 4'h0);
        end
        rst = 1'b0;
        d0 = done_cnt[0];
        repeat (100) @(negedge clk_m);
        chk("no_done_after_rst", done_cnt[0], d0);

        // Pointer back at 0: {2,0} pending picks 0, then 2
        req_data[7:0]   = 8'h5A;
        req_data[23:16] = 8'hC3;
        push(4'b0001, 8'h5A, 8'h3C);
        push(4'b0100, 8'hC3, 8'h3C);
        req = 4'b0101;
        @(negedge clk_m);
        for (int m = 0; m < NI; m++) begin
            chk($sformatf("lat1_grant m%0d", m), grant_a[m], 4'b0001);
            chk($sformatf("lat1_ss m%0d", m), ss_a[m], 4'b1110);
        end
        wait_done("ptr0");
        req = 4'b0100;
        wait_done("ptr2");
        req = 4'h0;

        // req[1] dropped mid-transfer: completes once, no retry
        repeat (3) @(negedge clk_m);
        req_data[15:8] = 8'h96;
        push(4'b0010, 8'h96, 8'h3C);
        req = 4'b0010;
        repeat (40) @(negedge clk_m);
        req = 4'h0;
        wait_done("drop");
        flag = 0;
        repeat (60) begin
            @(negedge clk_m);
            if (grant_a[0] != 4'h0) flag = 1;
        end
        chk("no_retry", flag, 0);

        // Wide/fast instance latency: done in cycle 69
        data5[15:0] = 16'hBEEF;
        lat_q.push_back(cyc + 69);
        req5 = 4'b0001;
        n = 0;
        do begin
            @(negedge clk_m);
            n++;
        end while (!done5 && n < 300);
        if (!done5) chk("timeout done16", 0, 1);
        req5 = 4'h0;
        repeat (5) @(negedge clk_m);

        for (int m = 0; m < NI; m++)
            chk($sformatf("all_done m%0d", m), rd[m], exp_q.size());
        chk("lat_q_drained", lat_q.size(), 0);
        chk("protocol_violations", viol, 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
